// File: rtl/color_pkg.sv
// Shared filter-select codes and sequencer state encoding for the colour sensor path.
// The classifier reuses the FILT_* codes.
package color_pkg;

    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    // Per-filter states are consecutive so SETTLE -> GATE -> STORE -> next SETTLE is +1.
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_SETTLE_R = 4'd1;
    localparam logic [3:0] ST_GATE_R   = 4'd2;
    localparam logic [3:0] ST_STORE_R  = 4'd3;
    localparam logic [3:0] ST_SETTLE_B = 4'd4;
    localparam logic [3:0] ST_GATE_B   = 4'd5;
    localparam logic [3:0] ST_STORE_B  = 4'd6;
    localparam logic [3:0] ST_SETTLE_G = 4'd7;
    localparam logic [3:0] ST_GATE_G   = 4'd8;
    localparam logic [3:0] ST_STORE_G  = 4'd9;
    localparam logic [3:0] ST_SETTLE_C = 4'd10;
    localparam logic [3:0] ST_GATE_C   = 4'd11;
    localparam logic [3:0] ST_STORE_C  = 4'd12;
    localparam logic [3:0] ST_HOLD     = 4'd13;

    typedef enum logic [3:0] {
        IDLE     = ST_IDLE,
        SETTLE_R = ST_SETTLE_R,
        GATE_R   = ST_GATE_R,
        STORE_R  = ST_STORE_R,
        SETTLE_B = ST_SETTLE_B,
        GATE_B   = ST_GATE_B,
        STORE_B  = ST_STORE_B,
        SETTLE_G = ST_SETTLE_G,
        GATE_G   = ST_GATE_G,
        STORE_G  = ST_STORE_G,
        SETTLE_C = ST_SETTLE_C,
        GATE_C   = ST_GATE_C,
        STORE_C  = ST_STORE_C,
        HOLD     = ST_HOLD
    } state_t;

endpackage

// File: rtl/edge_gate_counter.sv
// Synchronises the sensor square wave, detects rising edges and counts them
// into a saturating counter while enabled.
module edge_gate_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             colorsignal,
    output logic [CNT_W-1:0] count
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;
    logic rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0/p1: two-flop synchroniser; stage p2: previous value for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            meta_p0 <= colorsignal;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && rise)
            count <= sat_inc(count);
    end

endmodule

// File: rtl/color_scan_sequencer.sv
// Steps the colour sensor through red, blue, green, clear filters, counts edges
// per gate window and publishes a 4-channel sample over a valid/ack handshake.
module color_scan_sequencer
    import color_pkg::*;
#(
    parameter int SETTLE_CYCLES = 10_000,
    parameter int GATE_CYCLES   = 1_000_000,
    parameter int CNT_W         = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             colorsignal,
    output logic             s2,
    output logic             s3,
    output logic             busy,
    output logic [CNT_W-1:0] red,
    output logic [CNT_W-1:0] blue,
    output logic [CNT_W-1:0] green,
    output logic [CNT_W-1:0] clear,
    output logic             sample_valid,
    input  logic             sample_ack
);

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

    state_t           state, state_nx;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] shd_r, shd_b, shd_g;
    logic             cnt_clr, cnt_en;
    logic [1:0]       filt_nx;

    edge_gate_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock       (clock),
        .reset       (reset),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .colorsignal (colorsignal),
        .count       (count)
    );

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state)
            IDLE:
                if (run && !sample_valid) state_nx = SETTLE_R;
            SETTLE_R, SETTLE_B, SETTLE_G, SETTLE_C:
                if (tmr == SETTLE_LAST) begin
                    state_nx = state_t'(state + 4'd1);
                    cnt_clr  = 1'b1;
                end
            GATE_R, GATE_B, GATE_G, GATE_C: begin
                cnt_en = 1'b1;
                if (tmr == GATE_LAST) state_nx = state_t'(state + 4'd1);
            end
            STORE_R, STORE_B, STORE_G, STORE_C:
                state_nx = state_t'(state + 4'd1);
            HOLD:
                state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase

        // Filter lines only move when a new SETTLE phase (or IDLE) is entered.
        unique case (state_nx)
            IDLE, SETTLE_R: filt_nx = FILT_RED;
            SETTLE_B:       filt_nx = FILT_BLUE;
            SETTLE_G:       filt_nx = FILT_GREEN;
            SETTLE_C:       filt_nx = FILT_CLEAR;
            default:        filt_nx = {s2, s3};
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tmr      <= '0;
            {s2, s3} <= FILT_RED;
        end else begin
            state    <= state_nx;
            {s2, s3} <= filt_nx;
            if (state_nx != state)
                tmr <= '0;
            else if (cnt_en || state inside {SETTLE_R, SETTLE_B, SETTLE_G, SETTLE_C})
                tmr <= tmr + TMR_W'(1);
        end
    end

    // Clear is taken straight from the counter so all four outputs update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shd_r <= '0;
            shd_b <= '0;
            shd_g <= '0;
            red   <= '0;
            blue  <= '0;
            green <= '0;
            clear <= '0;
        end else begin
            case (state)
                STORE_R: shd_r <= count;
                STORE_B: shd_b <= count;
                STORE_G: shd_g <= count;
                STORE_C: begin
                    red   <= shd_r;
                    blue  <= shd_b;
                    green <= shd_g;
                    clear <= count;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sample_valid <= 1'b0;
        else if (state == HOLD)
            sample_valid <= 1'b1;
        else if (sample_valid && sample_ack)
            sample_valid <= 1'b0;
    end

    assign busy = (state != IDLE) && (state != HOLD);

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Scenario bench for color_scan_sequencer with short settle/gate windows and a
// second CNT_W=3 instance sharing all inputs to observe saturation.
module tb_color_scan_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       colorsignal;
    logic       sample_ack;
    logic       s2, s3, busy, sample_valid;
    logic [3:0] red, blue, green, clear;
    logic       s2_3, s3_3, busy_3, sample_valid_3;
    logic [2:0] red_3, blue_3, green_3, clear_3;

    typedef struct {
        logic [3:0] r;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] c;
    } exp_t;

    exp_t sb[$];
    bit   pat [0:159];
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    color_scan_sequencer #(.SETTLE_CYCLES(4), .GATE_CYCLES(16), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .colorsignal  (colorsignal),
        .s2           (s2),
        .s3           (s3),
        .busy         (busy),
        .red          (red),
        .blue         (blue),
        .green        (green),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_ack   (sample_ack)
    );

    color_scan_sequencer #(.SETTLE_CYCLES(4), .GATE_CYCLES(16), .CNT_W(3)) dut3 (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .colorsignal  (colorsignal),
        .s2           (s2_3),
        .s3           (s3_3),
        .busy         (busy_3),
        .red          (red_3),
        .blue         (blue_3),
        .green        (green_3),
        .clear        (clear_3),
        .sample_valid (sample_valid_3),
        .sample_ack   (sample_ack)
    );

    function automatic logic [2:0] sat3(input logic [3:0] v);
        return (v > 4'd7) ? 3'd7 : v[2:0];
    endfunction

    // Scan cycle k = cycles after the edge that sampled run in IDLE; 21 cycles per filter.
    function automatic logic [1:0] exp_filt(input int k);
        if (k < 21) return 2'b00;
        if (k < 42) return 2'b01;
        if (k < 63) return 2'b11;
        return 2'b10;
    endfunction

    task automatic clear_pat();
        foreach (pat[i]) pat[i] = 1'b0;
    endtask

    // Input rise at cycle k reaches the edge detector at cycle k+2.
    task automatic add_gate_edges(input int ch, input int n);
        for (int m = 0; m < n; m++) pat[ch*21 + 3 + 2*m] = 1'b1;
    endtask

    task automatic add_settle_edges(input int ch);
        if (ch > 0) pat[ch*21 - 1] = 1'b1;
        pat[ch*21 + 1] = 1'b1;
    endtask

    task automatic fill_period4();
        clear_pat();
        for (int k = 0; k < 160; k++) pat[k] = ((k % 4) < 2);
    endtask

    task automatic start_run(input bit keep_high);
        @(posedge clock); #1;
        run = 1'b1;
        colorsignal = 1'b0;
        @(posedge clock); #1;
        if (!keep_high) run = 1'b0;
    endtask

    // Entered at scan cycle 0; returns at the first cycle sample_valid is high.
    task automatic run_scan(input string name, output exp_t e);
        int seen;
        seen = -1;
        for (int k = 0; k < 150; k++) begin
            if (sample_valid) begin
                seen = k;
                break;
            end
            vectors++;
            if ({s2, s3} !== exp_filt(k)) begin
                miscompares++;
                $display("FAIL %s s2s3 cycle %0d: got %b expected %b", name, k, {s2, s3}, exp_filt(k));
            end
            vectors++;
            if (busy !== (k < 84)) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, busy, (k < 84));
            end
            colorsignal = pat[k];
            @(posedge clock); #1;
        end
        vectors++;
        if (seen != 85) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected 86 (-1 = timeout)", name, (seen < 0) ? -1 : seen + 1);
        end
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", name);
            e = '{r: 4'd0, b: 4'd0, g: 4'd0, c: 4'd0};
        end else begin
            e = sb.pop_front();
        end
        vectors += 9;
        if (red !== e.r)   begin miscompares++; $display("FAIL %s red: got %0d expected %0d", name, red, e.r); end
        if (blue !== e.b)  begin miscompares++; $display("FAIL %s blue: got %0d expected %0d", name, blue, e.b); end
        if (green !== e.g) begin miscompares++; $display("FAIL %s green: got %0d expected %0d", name, green, e.g); end
        if (clear !== e.c) begin miscompares++; $display("FAIL %s clear: got %0d expected %0d", name, clear, e.c); end
        if (red_3 !== sat3(e.r))   begin miscompares++; $display("FAIL %s red_w3: got %0d expected %0d", name, red_3, sat3(e.r)); end
        if (blue_3 !== sat3(e.b))  begin miscompares++; $display("FAIL %s blue_w3: got %0d expected %0d", name, blue_3, sat3(e.b)); end
        if (green_3 !== sat3(e.g)) begin miscompares++; $display("FAIL %s green_w3: got %0d expected %0d", name, green_3, sat3(e.g)); end
        if (clear_3 !== sat3(e.c)) begin miscompares++; $display("FAIL %s clear_w3: got %0d expected %0d", name, clear_3, sat3(e.c)); end
        if (sample_valid_3 !== 1'b1) begin miscompares++; $display("FAIL %s valid_w3: got %b expected 1", name, sample_valid_3); end
    endtask

    task automatic ack_step(input string name);
        sample_ack = 1'b1;
        @(posedge clock); #1;
        sample_ack = 1'b0;
        vectors++;
        if (sample_valid !== 1'b0 || sample_valid_3 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ack: got valid %b/%b expected 0/0", name, sample_valid, sample_valid_3);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; colorsignal = 1'b0; sample_ack = 1'b0;
        #1 reset = 1'b1;
        #1;
        vectors += 3;
        if ({s2, s3} !== 2'b00) begin miscompares++; $display("FAIL reset s2s3: got %b expected 00", {s2, s3}); end
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset busy/valid: got %b/%b expected 0/0", busy, sample_valid);
        end
        if ({red, blue, green, clear} !== 16'h0) begin
            miscompares++; $display("FAIL reset counts: got %h expected 0000", {red, blue, green, clear});
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset release: got busy %b valid %b expected 0/0", busy, sample_valid);
        end
    endtask

    task automatic test_single_scan();
        exp_t e;
        fill_period4();
        sb.push_back('{r: 4'd4, b: 4'd4, g: 4'd4, c: 4'd4});
        start_run(1'b0);
        run_scan("single", e);
        ack_step("single");
    endtask

    task automatic test_reset_mid_scan();
        fill_period4();
        start_run(1'b0);
        for (int k = 0; k < 50; k++) begin
            colorsignal = pat[k];
            @(posedge clock); #1;
        end
        vectors++;
        if ({s2, s3} !== 2'b11) begin miscompares++; $display("FAIL midreset pre s2s3: got %b expected 11", {s2, s3}); end
        reset = 1'b1;
        #1;
        vectors += 3;
        if ({s2, s3} !== 2'b00 || busy !== 1'b0) begin
            miscompares++; $display("FAIL midreset s2s3/busy: got %b/%b expected 00/0", {s2, s3}, busy);
        end
        if ({red, blue, green, clear} !== 16'h0) begin
            miscompares++; $display("FAIL midreset counts: got %h expected 0000", {red, blue, green, clear});
        end
        if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL midreset valid: got %b expected 0", sample_valid); end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 150; k++) begin
            colorsignal = pat[k];
            @(posedge clock); #1;
            vectors++;
            if (sample_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset idle cycle %0d: got valid %b busy %b expected 0/0", k, sample_valid, busy);
            end
        end
    endtask

    task automatic test_channel_rates();
        exp_t e;
        clear_pat();
        add_gate_edges(0, 8);
        add_gate_edges(1, 2);
        add_gate_edges(2, 5);
        add_gate_edges(3, 7);
        for (int ch = 0; ch < 4; ch++) add_settle_edges(ch);
        sb.push_back('{r: 4'd8, b: 4'd2, g: 4'd5, c: 4'd7});
        start_run(1'b0);
        run_scan("rates", e);
        ack_step("rates");
    endtask

    task automatic test_saturation();
        exp_t e;
        clear_pat();
        for (int k = 0; k < 160; k++) pat[k] = k[0];
        sb.push_back('{r: 4'd8, b: 4'd8, g: 4'd8, c: 4'd8});
        start_run(1'b0);
        run_scan("saturate", e);
        ack_step("saturate");
    endtask

    task automatic test_gate_boundary();
        exp_t e;
        clear_pat();
        pat[17] = 1'b1;
        sb.push_back('{r: 4'd1, b: 4'd0, g: 4'd0, c: 4'd0});
        start_run(1'b0);
        run_scan("gate_last", e);
        ack_step("gate_last");
        clear_pat();
        pat[18] = 1'b1;
        sb.push_back('{r: 4'd0, b: 4'd0, g: 4'd0, c: 4'd0});
        start_run(1'b0);
        run_scan("store_edge", e);
        ack_step("store_edge");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        fill_period4();
        sb.push_back('{r: 4'd4, b: 4'd4, g: 4'd4, c: 4'd4});
        start_run(1'b1);
        run_scan("b2b_first", e);
        for (int k = 0; k < 200; k++) begin
            colorsignal = pat[k];
            @(posedge clock); #1;
            vectors++;
            if (sample_valid !== 1'b1 || busy !== 1'b0 || {red, blue, green, clear} !== {e.r, e.b, e.g, e.c}) begin
                miscompares++;
                $display("FAIL park cycle %0d: got valid %b busy %b counts %h expected 1 0 %h",
                         k, sample_valid, busy, {red, blue, green, clear}, {e.r, e.b, e.g, e.c});
            end
        end
        ack_step("b2b_ack");
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b busy at ack: got %b expected 0", busy); end
        sb.push_back('{r: 4'd4, b: 4'd4, g: 4'd4, c: 4'd4});
        @(posedge clock); #1;
        run = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b restart: got busy %b expected 1", busy); end
        run_scan("b2b_second", e);
        ack_step("b2b_second");
        for (int k = 0; k < 30; k++) begin
            @(posedge clock); #1;
            vectors++;
            if (busy !== 1'b0 || sample_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b idle cycle %0d: got busy %b valid %b expected 0/0", k, busy, sample_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_reset_mid_scan();
        test_channel_rates();
        test_saturation();
        test_gate_boundary();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
